dmi_access_ctrl: RTL
====================

// Module: dmi_access_ctrl
// PURPOSE
// - DTM-side DMI access engine: owns the 41-bit dmi DR (addr[40:34], data[33:2], op[1:0]) behind the TAP.
// - Converts TAP capture/shift/update pulses into dm::dmi_req_t transactions; collects dm::dmi_resp_t.
// - Tracks the sticky dmistat error. Directly upstream of the debug module's DMI slave.
// - The TAP controller runs synchronous to clk_i; any CDC sits outside this block.
// PARAMETERS
// - AbitsW  7  DMI address width; must equal width of dm::dmi_req_t.addr.
// - DrW     41 dmi DR length = AbitsW + 32 + 2.
// PORTS
// - clk_i             in   1   clock (single clock domain)
// - rst_ni            in   1   asynchronous, active-low reset
// - dmi_select_i      in   1   IR currently selects the dmi DR
// - capture_dr_i      in   1   TAP Capture-DR pulse
// - shift_dr_i        in   1   TAP Shift-DR, one bit per cycle
// - update_dr_i       in   1   TAP Update-DR pulse
// - tdi_i             in   1   serial in
// - tdo_o             out  1   serial out = shift_q[0]
// - dmi_reset_i       in   1   dtmcs.dmireset pulse: clear sticky error
// - dmi_hardreset_i   in   1   dtmcs.dmihardreset pulse: abort and clear
// - dmi_req_o         out  41  dm::dmi_req_t {addr, op, data}
// - dmi_req_valid_o   out  1   request valid
// - dmi_req_ready_i   in   1   DM accepts request
// - dmi_resp_i        in   34  dm::dmi_resp_t {data, resp}
// - dmi_resp_valid_i  in   1   response valid
// - dmi_resp_ready_o  out  1   engine accepts response
// - dmi_status_o      out  2   sticky error for dtmcs.dmistat (0 ok, 2 failed, 3 busy)
// - dmi_busy_o        out  1   transaction outstanding (state != Idle)
// BEHAVIOUR
// - Reset: state=Idle, shift_q=0, addr_q=0, data_q=0, error_q=0.
//   All outputs 0 (tdo_o=0, dmi_req_o='0, dmi_req_valid_o=0, dmi_resp_ready_o=0, dmi_status_o=0, dmi_busy_o=0).
// - TAP ops act only when dmi_select_i=1. Priority if several are asserted: capture > shift > update.
// - Capture: shift_q <= {addr_q, data_q, st}.
//   st = error_q if error_q!=0, else 3 when busy (also sets error_q=3), else 0.
// - Shift: shift_q <= {tdi_i, shift_q[DrW-1:1]}. tdo_o follows shift_q[0] (registered, no comb path).
// - Update, decoding op = shift_q[1:0]:
//   - error_q!=0 -> ignored entirely.
//   - busy -> ignored and error_q<=3.
//   - DTM_READ -> addr_q<=shift_q[40:34], go Req.
//   - DTM_WRITE -> addr_q, data_q <= shift_q fields, go Req.
//   - NOP or op=3 -> no effect.
// - FSM Idle -> Req -> Wait -> Idle; Flush entered only from a hardreset.
//   - Req: dmi_req_valid_o=1, req = {addr_q, latched op, data_q}. Valid and payload held stable until
//     dmi_req_ready_i; on ready go Wait the next cycle. No combinational ready->valid path.
//   - Wait: dmi_resp_ready_o=1. On dmi_resp_valid_i:
//     - read -> data_q<=resp.data;
//     - resp.resp!=0 -> error_q<=resp.resp (error_q never lowered here);
//     - go Idle.
//   - Minimum latency update->req_valid = 1 cycle; resp accept -> next capture reflects data in the same cycle.
// - dmi_reset_i: error_q<=0 only; an outstanding transaction continues. If same cycle as an update that
//   would set busy, the clear wins.
// - dmi_hardreset_i: error_q<=0; Req -> Idle (valid drops, transaction withdrawn);
//   Wait -> Flush (resp_ready=1, discard one response, then Idle); Idle/Flush unchanged.
//   Takes precedence over a coincident update (the update is dropped).
// - dmi_status_o = error_q; dmi_busy_o = (state != Idle).
// - Async reset mid-transaction: immediate return to reset values; no response is consumed.
// STRUCTURE
// - Package dm gains: localparam DmiDrWidth=41; enum dmi_status_t {DmiNoError=0, DmiOpFailed=2, DmiBusy=3}.
//   Existing dtm_op_t, dmi_req_t and dmi_resp_t are reused unchanged.
// - Single module, no sub-modules; the shift register and FSM are both inline.
// TESTING
// - Write: shift {addr=0x10, data=0x1, op=2}, update, ready after 3 cycles -> one req {0x10, WRITE, 0x1};
//   valid held 3 cycles; busy falls after the response.
// - Read: op=1 addr=0x11, resp.data=0x00400C82 -> next capture shifts out data 0x00400C82, status 0.
// - Busy: update again while in Wait -> no second req, status=3 sticky; later updates ignored until
//   dmi_reset_i, then a write succeeds.
// - Error: resp.resp=2 -> dmi_status_o=2, captured st=2; dmi_reset_i -> 0.
// - Hardreset in Req -> valid drops next cycle; in Wait -> the next response is discarded, data_q unchanged.
// - Reset asserted during Req -> all outputs 0 asynchronously; NOP update -> no request issued.

Source files
------------

// File: rtl/dm_pkg.sv
// Debug-module shared types: DMI request/response payloads, DTM op codes and dmistat codes.
package dm;

    localparam int unsigned DmiDrWidth = 41;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'h0,
        DTM_READ  = 2'h1,
        DTM_WRITE = 2'h2
    } dtm_op_t;

    typedef enum logic [1:0] {
        DmiNoError  = 2'h0,
        DmiOpFailed = 2'h2,
        DmiBusy     = 2'h3
    } dmi_status_t;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_t     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_access_ctrl.sv
// DTM-side DMI access engine: owns the dmi DR, turns TAP update pulses into DMI
// requests, collects responses and keeps the sticky dmistat error.
module dmi_access_ctrl
    import dm::*;
#(
    parameter int unsigned AbitsW = 7,
    parameter int unsigned DrW    = DmiDrWidth
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      dmi_select_i,
    input  logic      capture_dr_i,
    input  logic      shift_dr_i,
    input  logic      update_dr_i,
    input  logic      tdi_i,
    output logic      tdo_o,
    input  logic      dmi_reset_i,
    input  logic      dmi_hardreset_i,
    output dmi_req_t  dmi_req_o,
    output logic      dmi_req_valid_o,
    input  logic      dmi_req_ready_i,
    input  dmi_resp_t dmi_resp_i,
    input  logic      dmi_resp_valid_i,
    output logic      dmi_resp_ready_o,
    output logic [1:0] dmi_status_o,
    output logic      dmi_busy_o
);

    typedef enum logic [1:0] {Idle, Req, Wait, Flush} state_e;

    state_e            state_q, state_d;
    logic [DrW-1:0]    shift_q, shift_d;
    logic [AbitsW-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    dtm_op_t           op_q, op_d;
    logic [1:0]        error_q, error_d;

    logic       busy;
    logic       do_capture, do_shift, do_update;
    logic [1:0] cap_status;

    assign busy       = (state_q != Idle);
    assign do_capture = dmi_select_i & capture_dr_i;
    assign do_shift   = dmi_select_i & shift_dr_i & ~capture_dr_i;
    // A coincident hardreset drops the update entirely.
    assign do_update  = dmi_select_i & update_dr_i & ~capture_dr_i & ~shift_dr_i & ~dmi_hardreset_i;
    assign cap_status = (error_q != 2'd0) ? error_q : (busy ? DmiBusy : DmiNoError);

    always_comb begin
        state_d          = state_q;
        shift_d          = shift_q;
        addr_d           = addr_q;
        data_d           = data_q;
        op_d             = op_q;
        error_d          = error_q;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        dmi_req_o        = '0;

        if (do_capture) begin
            shift_d = {addr_q, data_q, cap_status};
            if (error_q == 2'd0 && busy) error_d = DmiBusy;
        end else if (do_shift) begin
            shift_d = {tdi_i, shift_q[DrW-1:1]};
        end

        if (do_update && error_q == 2'd0) begin
            if (busy) begin
                error_d = DmiBusy;
            end else if (shift_q[1:0] == DTM_READ) begin
                addr_d  = shift_q[DrW-1 -: AbitsW];
                op_d    = DTM_READ;
                state_d = Req;
            end else if (shift_q[1:0] == DTM_WRITE) begin
                addr_d  = shift_q[DrW-1 -: AbitsW];
                data_d  = shift_q[2 +: 32];
                op_d    = DTM_WRITE;
                state_d = Req;
            end
        end

        case (state_q)
            Req: begin
                dmi_req_valid_o = 1'b1;
                dmi_req_o       = '{addr: addr_q, op: op_q, data: data_q};
                if (dmi_hardreset_i)      state_d = Idle;
                else if (dmi_req_ready_i) state_d = Wait;
            end
            Wait: begin
                dmi_resp_ready_o = 1'b1;
                // A response arriving with the hardreset is consumed but its contents dropped.
                if (dmi_resp_valid_i) begin
                    state_d = Idle;
                    if (!dmi_hardreset_i) begin
                        if (op_q == DTM_READ) data_d = dmi_resp_i.data;
                        if (dmi_resp_i.resp != 2'd0) error_d = dmi_resp_i.resp;
                    end
                end else if (dmi_hardreset_i) begin
                    state_d = Flush;
                end
            end
            Flush: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) state_d = Idle;
            end
            default: ;
        endcase

        if (dmi_reset_i || dmi_hardreset_i) error_d = DmiNoError;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            shift_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= DTM_NOP;
            error_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            op_q    <= op_d;
            error_q <= error_d;
        end
    end

    assign tdo_o        = shift_q[0];
    assign dmi_status_o = error_q;
    assign dmi_busy_o   = busy;

endmodule
